// File: rtl/dmem_arbiter_if.sv
// Requester-side and Data_Memory-side signal bundle for dmem_arbiter.
// slave = the arbiter; master = the requesters plus the attached memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              a_req,   b_req;
  logic              a_we,    b_we;
  logic [1:0]        a_size,  b_size;
  logic              a_uns,   b_uns;
  logic [ADDR_W-1:0] a_addr,  b_addr;
  logic [31:0]       a_wdata, b_wdata;

  logic              a_gnt,   b_gnt;
  logic              a_done,  b_done;
  logic [31:0]       a_rdata, b_rdata;
  logic              a_err,   b_err;

  logic [1:0]        mem_we;
  logic [2:0]        mem_rd_type;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_size, b_size, a_uns, b_uns,
           a_addr, b_addr, a_wdata, b_wdata, mem_dout,
    output a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, a_err, b_err,
           mem_we, mem_rd_type, mem_wr_addr, mem_rd_addr, mem_din
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_size, b_size, a_uns, b_uns,
           a_addr, b_addr, a_wdata, b_wdata, mem_dout,
    input  a_gnt, b_gnt, a_done, b_done, a_rdata, b_rdata, a_err, b_err,
           mem_we, mem_rd_type, mem_wr_addr, mem_rd_addr, mem_din
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of Data_Memory: IDLE -> ACCESS -> DONE.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round robin.
module dmem_arbiter #(
  parameter int MEMORY_SIZE = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic         Clk,
  input  logic         Rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEMORY_SIZE);

  // Extra address bit keeps addr + bytes - 1 from wrapping near the top.
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] last_byte;
    logic            bad;
    last_byte = {1'b0, addr};
    bad       = 1'b0;
    case (size)
      2'b00: bad = 1'b0;
      2'b01: begin
        last_byte = {1'b0, addr} + (ADDR_W+1)'(1);
        bad       = addr[0];
      end
      2'b10: begin
        last_byte = {1'b0, addr} + (ADDR_W+1)'(3);
        bad       = |addr[1:0];
      end
      default: bad = 1'b1;
    endcase
    return bad | (last_byte >= MEM_LIMIT);
  endfunction

  state_t            state_q, state_d;
  logic              sel_b;
  logic              any_req;
  logic              latch_en;

  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_uns;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  logic              owner_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_pending_q;

  logic              a_gnt_q,  a_gnt_d,  b_gnt_q,  b_gnt_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic              a_err_q,  a_err_d,  b_err_q,  b_err_d;
  logic [31:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [31:0]       rd_capture;

  assign any_req = bus.a_req | bus.b_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign sel_b = bus.b_req & ~bus.a_req;
`else
  logic last_owner_q, last_owner_d;

  // On a tie the port that did not own the previous access wins.
  assign sel_b        = bus.b_req & (~bus.a_req | ~last_owner_q);
  assign last_owner_d = (state_q == DONE) ? owner_q : last_owner_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) last_owner_q <= 1'b1;
    else        last_owner_q <= last_owner_d;
  end
`endif

  assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
  assign sel_size  = sel_b ? bus.b_size  : bus.a_size;
  assign sel_uns   = sel_b ? bus.b_uns   : bus.a_uns;
  assign sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

  assign rd_capture = (!err_pending_q && !we_q) ? bus.mem_dout : 32'h0;

  always_comb begin
    state_d          = state_q;
    latch_en         = 1'b0;
    a_gnt_d          = 1'b0;
    b_gnt_d          = 1'b0;
    a_done_d         = 1'b0;
    b_done_d         = 1'b0;
    a_err_d          = 1'b0;
    b_err_d          = 1'b0;
    a_rdata_d        = a_rdata_q;
    b_rdata_d        = b_rdata_q;
    bus.mem_we       = 2'b00;
    bus.mem_rd_type  = 3'b000;
    bus.mem_wr_addr  = '0;
    bus.mem_rd_addr  = '0;
    bus.mem_din      = 32'h0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          latch_en = 1'b1;
          state_d  = ACCESS;
          a_gnt_d  = ~sel_b;
          b_gnt_d  = sel_b;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!err_pending_q) begin
          bus.mem_wr_addr = addr_q;
          bus.mem_rd_addr = addr_q;
          bus.mem_din     = wdata_q;
          bus.mem_rd_type = {uns_q, size_q};
          bus.mem_we      = we_q ? (size_q + 2'd1) : 2'b00;
        end
        if (owner_q) begin
          b_rdata_d = rd_capture;
          b_done_d  = 1'b1;
          b_err_d   = err_pending_q;
        end else begin
          a_rdata_d = rd_capture;
          a_done_d  = 1'b1;
          a_err_d   = err_pending_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= 32'h0;
      b_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      a_gnt_q   <= a_gnt_d;
      b_gnt_q   <= b_gnt_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Request fields are only consumed after a grant, so they need no reset.
  always_ff @(posedge Clk) begin
    if (latch_en) begin
      owner_q       <= sel_b;
      we_q          <= sel_we;
      size_q        <= sel_size;
      uns_q         <= sel_uns;
      addr_q        <= sel_addr;
      wdata_q       <= sel_wdata;
      err_pending_q <= access_illegal(sel_size, sel_addr);
    end
  end

  assign bus.a_gnt   = a_gnt_q;
  assign bus.b_gnt   = b_gnt_q;
  assign bus.a_done  = a_done_q;
  assign bus.b_done  = b_done_q;
  assign bus.a_err   = a_err_q;
  assign bus.b_err   = b_err_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array Data_Memory model.
// Expected responses are predicted at grant time from a reference memory.
module tb_dmem_arbiter;
  localparam int MS = 1024;
  localparam int AW = 32;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  dmem_arbiter_if #(.ADDR_W(AW)) bus ();
  dmem_arbiter #(.MEMORY_SIZE(MS), .ADDR_W(AW)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          we_cycles = 0;
  int          done_seen = 0;
  int          gnt_cyc [2];
  logic [31:0] last_rd [2];
  txn_t        cur [2];
  int          gnt_log [$];
  rsp_t        exp_a [$];
  rsp_t        exp_b [$];
  logic [7:0]  dm [MS];
  logic [7:0]  rm [MS];
  bit          dm_seeded = 1'b0;
  bit          rm_seeded = 1'b0;
  logic [31:0] rd_base, rd_raw, rd_val;

  function automatic logic [7:0] seed_byte(int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  function automatic int nbytes(logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- Data_Memory model ----------------
  always @(posedge Clk) begin
    if (!dm_seeded) begin
      for (int i = 0; i < MS; i++) dm[i] <= seed_byte(i);
      dm_seeded <= 1'b1;
    end else if (bus.mem_we != 2'b00) begin
      for (int k = 0; k < 4; k++)
        if (k < nbytes(bus.mem_we - 2'd1) && (bus.mem_wr_addr + 32'(k)) < 32'(MS))
          dm[bus.mem_wr_addr + 32'(k)] <= bus.mem_din[8*k +: 8];
    end
  end

  always_comb begin
    rd_base = bus.mem_rd_addr % 32'(MS);
    rd_raw  = {dm[(rd_base + 32'd3) % 32'(MS)], dm[(rd_base + 32'd2) % 32'(MS)],
               dm[(rd_base + 32'd1) % 32'(MS)], dm[rd_base]};
    rd_val  = rd_raw;
    case (bus.mem_rd_type[1:0])
      2'b00:   rd_val = bus.mem_rd_type[2] ? {24'h0, rd_raw[7:0]} : {{24{rd_raw[7]}}, rd_raw[7:0]};
      2'b01:   rd_val = bus.mem_rd_type[2] ? {16'h0, rd_raw[15:0]} : {{16{rd_raw[15]}}, rd_raw[15:0]};
      default: rd_val = rd_raw;
    endcase
    bus.mem_dout = rd_val;
  end

  // ---------------- reference model ----------------
  function automatic bit ref_illegal(txn_t t);
    longint unsigned last_b;
    last_b = 64'(t.addr) + 64'(nbytes(t.size)) - 64'd1;
    if (t.size == 2'd3) return 1'b1;
    if (t.size == 2'd1 && t.addr[0]) return 1'b1;
    if (t.size == 2'd2 && t.addr[1:0] != 2'b00) return 1'b1;
    return last_b >= 64'(MS);
  endfunction

  function automatic rsp_t ref_apply(txn_t t);
    rsp_t r;
    int n;
    logic [31:0] v;
    r.rdata = 32'h0;
    r.err   = ref_illegal(t);
    if (r.err) return r;
    n = nbytes(t.size);
    if (t.we) begin
      for (int k = 0; k < n; k++) rm[int'(t.addr) + k] = t.wdata[8*k +: 8];
      return r;
    end
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = rm[int'(t.addr) + k];
    if (!t.uns && n < 4)
      for (int k = 8 * n; k < 32; k++) v[k] = v[8*n - 1];
    r.rdata = v;
    return r;
  endfunction

  function automatic txn_t mk(logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.we = we; t.size = sz; t.uns = uns; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    rsp_t e;
    bit   ill;
    if (!rm_seeded) begin
      for (int i = 0; i < MS; i++) rm[i] = seed_byte(i);
      rm_seeded = 1'b1;
    end
    if (Rst_n) begin
      if (bus.mem_we != 2'b00) begin
        we_cycles++;
        chk("we_only_in_access", {31'h0, bus.a_gnt | bus.b_gnt}, 32'd1);
      end
      if (bus.a_gnt && bus.b_gnt) chk("single_gnt", 32'd2, 32'd1);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? bus.a_gnt : bus.b_gnt) begin
          gnt_cyc[p] = cyc;
          gnt_log.push_back(p);
          ill = ref_illegal(cur[p]);
          chk("mem_we_in_access", {30'h0, bus.mem_we},
              (cur[p].we && !ill) ? 32'(cur[p].size) + 32'd1 : 32'd0);
          if (!ill) chk("mem_addr", bus.mem_wr_addr, cur[p].addr);
          e = ref_apply(cur[p]);
          if (p == 0) exp_a.push_back(e); else exp_b.push_back(e);
        end
        if ((p == 0) ? bus.a_done : bus.b_done) begin
          done_seen++;
          chk("done_has_expect", (p == 0) ? exp_a.size() : exp_b.size(), 32'd1);
          if ((p == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0)) begin
            e = (p == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk((p == 0) ? "a_rdata" : "b_rdata", (p == 0) ? bus.a_rdata : bus.b_rdata, e.rdata);
            chk((p == 0) ? "a_err" : "b_err", {31'h0, (p == 0) ? bus.a_err : bus.b_err}, {31'h0, e.err});
            chk("done_after_gnt", cyc - gnt_cyc[p], 32'd1);
            chk("other_rdata_held", (p == 0) ? bus.b_rdata : bus.a_rdata, last_rd[1-p]);
            last_rd[p] = e.rdata;
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int p, input txn_t t, input logic req);
    if (p == 0) begin
      bus.a_req = req; bus.a_we = t.we; bus.a_size = t.size;
      bus.a_uns = t.uns; bus.a_addr = t.addr; bus.a_wdata = t.wdata;
    end else begin
      bus.b_req = req; bus.b_we = t.we; bus.b_size = t.size;
      bus.b_uns = t.uns; bus.b_addr = t.addr; bus.b_wdata = t.wdata;
    end
  endtask

  // Starts and ends one cycle after a posedge with the DUT back in IDLE.
  task automatic issue(input int p, input txn_t t, input bit solo, output rsp_t r);
    int n;
    bit got;
    cur[p] = t;
    drive(p, t, 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      @(posedge Clk); #1; n++;
      got = (p == 0) ? bus.a_gnt : bus.b_gnt;
    end
    r.rdata = 32'h0; r.err = 1'b1;
    if (!got) begin
      chk("gnt_timeout", 32'(n), 32'd0);
      drive(p, t, 1'b0);
      return;
    end
    if (solo) chk("gnt_latency", 32'(n), 32'd1);
    drive(p, mk($urandom_range(0, 1), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom), 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 5) begin
      @(posedge Clk); #1; n++;
      got = (p == 0) ? bus.a_done : bus.b_done;
    end
    if (!got) chk("done_timeout", 32'(n), 32'd0);
    else if (solo) chk("done_latency", 32'(n), 32'd1);
    r.rdata = (p == 0) ? bus.a_rdata : bus.b_rdata;
    r.err   = (p == 0) ? bus.a_err : bus.b_err;
    drive(p, t, 1'b0);
    @(posedge Clk); #1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   a;
    t.we    = 1'($urandom_range(0, 1));
    t.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    t.uns   = 1'($urandom_range(0, 1));
    a       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MS - 8, MS + 6))
                                          : int'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0 && t.size != 2'd3) a = a & ~(nbytes(t.size) - 1);
    t.addr  = 32'(a);
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rsp_t r;
    int   w0, d0;
    int   exp_order [4];
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    gnt_cyc[0] = 0; gnt_cyc[1] = 0;
    cur[0] = '0; cur[1] = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_gnt",  {30'h0, bus.a_gnt, bus.b_gnt}, 32'd0);
    chk("rst_done", {28'h0, bus.a_done, bus.b_done, bus.a_err, bus.b_err}, 32'd0);
    chk("rst_a_rdata", bus.a_rdata, 32'h0);
    chk("rst_b_rdata", bus.b_rdata, 32'h0);
    chk("rst_mem_we", {30'h0, bus.mem_we}, 32'd0);
    chk("rst_mem_bus", bus.mem_wr_addr | bus.mem_rd_addr | bus.mem_din | {29'h0, bus.mem_rd_type}, 32'd0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;

    // store then load a word through port A
    w0 = we_cycles;
    issue(0, mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF), 1'b1, r);
    chk("st_word_err", {31'h0, r.err}, 32'd0);
    chk("st_we_one_cycle", 32'(we_cycles - w0), 32'd1);
    issue(0, mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0), 1'b1, r);
    chk("ld_word", r.rdata, 32'hDEADBEEF);
    chk("ld_word_err", {31'h0, r.err}, 32'd0);

    // signed / unsigned byte loads on port B
    issue(0, mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h80000000), 1'b1, r);
    issue(1, mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0), 1'b1, r);
    chk("ld_byte_signed", r.rdata, 32'hFFFFFF80);
    issue(1, mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0), 1'b1, r);
    chk("ld_byte_unsigned", r.rdata, 32'h00000080);

    // both ports request continuously
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    gnt_log.delete();
    cur[0] = mk(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    cur[1] = mk(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    drive(0, cur[0], 1'b1);
    drive(1, cur[1], 1'b1);
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++) begin
      @(posedge Clk); #1;
    end
    drive(0, cur[0], 1'b0);
    drive(1, cur[1], 1'b0);
    @(posedge Clk); #1;
    chk("arb_grant_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gnt_log.size()) chk("arb_order", 32'(gnt_log[i]), 32'(exp_order[i]));

    // misaligned accesses never reach memory
    w0 = we_cycles;
    issue(0, mk(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000CAFE), 1'b1, r);
    chk("misal_half_err", {31'h0, r.err}, 32'd1);
    chk("misal_half_rdata", r.rdata, 32'h0);
    issue(0, mk(1'b0, 2'd2, 1'b0, 32'h22, 32'h0), 1'b1, r);
    chk("misal_word_err", {31'h0, r.err}, 32'd1);
    chk("misal_word_rdata", r.rdata, 32'h0);
    chk("misal_no_we", 32'(we_cycles - w0), 32'd0);
    issue(0, mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0), 1'b1, r);
    chk("misal_readback", r.rdata, {seed_byte(32'h23), seed_byte(32'h22), seed_byte(32'h21), seed_byte(32'h20)});

    // range boundary and illegal size on port B
    issue(1, mk(1'b0, 2'd2, 1'b0, 32'(MS - 2), 32'h0), 1'b1, r);
    chk("range_3fe_err", {31'h0, r.err}, 32'd1);
    issue(1, mk(1'b0, 2'd2, 1'b0, 32'(MS - 4), 32'h0), 1'b1, r);
    chk("range_3fc_err", {31'h0, r.err}, 32'd0);
    issue(1, mk(1'b0, 2'd1, 1'b1, 32'(MS - 2), 32'h0), 1'b1, r);
    chk("range_half_top_err", {31'h0, r.err}, 32'd0);
    issue(1, mk(1'b0, 2'd3, 1'b0, 32'h0, 32'h0), 1'b1, r);
    chk("size11_err", {31'h0, r.err}, 32'd1);

    // random concurrent traffic
    fork
      begin
        rsp_t ra;
        for (int i = 0; i < 25; i++) begin
          issue(0, rand_txn(), 1'b0, ra);
          repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
        end
      end
      begin
        rsp_t rb;
        for (int i = 0; i < 25; i++) begin
          issue(1, rand_txn(), 1'b0, rb);
          repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
        end
      end
    join
    repeat (4) begin @(posedge Clk); #1; end

    // reset during the ACCESS cycle of a store
    cur[0] = mk(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
    drive(0, cur[0], 1'b1);
    for (int i = 0; i < 5 && !bus.a_gnt; i++) begin
      @(posedge Clk); #1;
    end
    chk("we_before_reset", {30'h0, bus.mem_we}, 32'd3);
    Rst_n = 1'b0;
    #1;
    chk("we_async_drop", {30'h0, bus.mem_we}, 32'd0);
    drive(0, cur[0], 1'b0);
    exp_a.delete(); exp_b.delete();
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    gnt_log.delete();
    d0 = done_seen;
    repeat (5) begin @(posedge Clk); #1; end
    chk("post_rst_no_gnt", gnt_log.size(), 32'd0);
    chk("post_rst_no_done", 32'(done_seen - d0), 32'd0);
    chk("post_rst_rdata", bus.a_rdata, 32'h0);
    chk("no_spurious_write", {dm[32'h103], dm[32'h102], dm[32'h101], dm[32'h100]},
        {rm[32'h103], rm[32'h102], rm[32'h101], rm[32'h100]});
    issue(0, mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0), 1'b1, r);
    chk("post_rst_load_err", {31'h0, r.err}, 32'd0);

    chk("scoreboard_drained", 32'(exp_a.size() + exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of Data_Memory.
- Port A is the core load/store unit; port B is the program loader / debug DMA.
- Serialises one access at a time and drives Data_Memory's WE, RD_Type, WR_Addr, RD_Addr and Din.
- Registers the read data and flags misaligned or out-of-range accesses, so Data_Memory never sees an illegal request.

Parameters:
- MEMORY_SIZE, 1024: byte size of the attached Data_Memory; accesses touching any byte >= MEMORY_SIZE are errors.
- ADDR_W, 32: requester and memory address width.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  request; held high until done_x is seen.
- a_we, b_we  in  1  1 = store, 0 = load.
- a_size, b_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and raises err.
- a_uns, b_uns  in  1  load zero-extend (1) or sign-extend (0).
- a_addr, b_addr  in  ADDR_W  byte address.
- a_wdata, b_wdata  in  32  store data, LSB-aligned.
- a_gnt, b_gnt  out  1  one-cycle pulse: request accepted, registered.
- a_done, b_done  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  32  load result; valid while done_x is high and held until the next done_x.
- a_err, b_err  out  1  high with done_x when the access was rejected.
- mem_we  out  2  to Data_Memory WE: 00 none, 01 byte, 10 half, 11 word.
- mem_rd_type  out  3  to RD_Type: {uns, size}.
- mem_wr_addr, mem_rd_addr  out  ADDR_W  to WR_Addr / RD_Addr.
- mem_din  out  32  to Din.
- mem_dout  in  32  from Dout (combinational read).

Behaviour:
- Reset (async, Rst_n=0): state IDLE; all gnt, done and err = 0; rdata = 0; mem_we = 00; mem addresses, din and rd_type = 0; last_owner = B, so A wins the first tie.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE: sample requests at the clock edge.
  - No request: stay in IDLE.
  - One request: select that requester.
  - Both request: select the requester that is not last_owner (round robin).
  - On selection: latch the selected request fields, set owner, pulse gnt_owner for the following cycle, go to ACCESS.
  - Check legality in IDLE from the latched fields:
    - half with addr[0] = 1 is misaligned;
    - word with addr[1:0] != 0 is misaligned;
    - size = 11 is illegal;
    - addr + bytes − 1 >= MEMORY_SIZE is out of range.
  - Store the result in an err_pending register.
- ACCESS (exactly one cycle):
  - If !err_pending: drive the latched addr onto both mem_wr_addr and mem_rd_addr, drive mem_din and mem_rd_type, and drive mem_we = size+1 for stores or 00 for loads.
  - If err_pending: mem_we = 00 and no memory side effect.
  - The store commits on the edge that ends ACCESS.
  - On that same edge, capture mem_dout into owner rdata for legal loads; capture 0 for stores and for errors.
  - Go to DONE.
- DONE: done_owner = 1 and err_owner = err_pending for this one cycle. Update last_owner = owner. Drive the memory outputs back to idle (mem_we = 00). Go to IDLE.
- Latency: request sampled at edge N, gnt high in cycle N+1, done high in cycle N+2. Throughput is one access per 3 cycles.
- mem_we is never nonzero outside ACCESS.
- Requester inputs may change after gnt; latched values are used.
- A requester that drops req before gnt is ignored; there is no partial state.
- A req still high during DONE is only re-arbitrated in the next IDLE.
- The non-owner's outputs stay 0 and its rdata is held.
- Reset asserted mid-ACCESS aborts immediately.
  - mem_we drops asynchronously; a write may be lost, but no spurious write occurs afterward.
  - No done pulse is issued.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins ties; last_owner is neither used nor updated, so B can starve.
- Undefined (default): round-robin tie-break as described in Behaviour.

Test Plan:
- A only, store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_we=11 for one cycle; a_gnt in cycle N+1, a_done in N+2; a_rdata=0xDEADBEEF, a_err=0.
- B load byte signed @0x13 after A stored 0x80000000 @0x10 -> b_rdata=0xFFFFFF80; with b_uns=1 -> 0x00000080.
- A and B request simultaneously and continuously -> grant order A,B,A,B (4 accesses), each done 1 cycle after its gnt; with DMEM_ARB_FIXED_PRIO_EN -> A,A,A,A.
- A half store @0x21 and word load @0x22 -> mem_we stays 00; a_err=1 with a_done; a_rdata=0; memory unchanged on readback.
- B word load @MEMORY_SIZE-2 (0x3FE) -> b_err=1, no access; word @0x3FC -> b_err=0.
- Assert Rst_n=0 during ACCESS of a store -> mem_we 00 asynchronously; after release, state IDLE; no done or gnt until a new req arrives.
